disp_axil_regbus: RTL and testbench

DISP_AXIL_REGBUS -- requirements
Module: disp_axil_regbus

---
 rtl/disp_axil_regbus.sv | 184 ++++++++++++++++++
 tb/tb_disp_axil_regbus.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_axil_regbus.sv
// AXI4-Lite slave bridging to a simple register bus with single-cycle WREN/RDEN
// strobes and a fixed-latency read data return.
module disp_axil_regbus #(
  parameter int RD_LATENCY = 1
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [15:0] S_AWADDR,
  input  logic        S_AWVALID,
  output logic        S_AWREADY,
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  input  logic        S_WVALID,
  output logic        S_WREADY,
  output logic [1:0]  S_BRESP,
  output logic        S_BVALID,
  input  logic        S_BREADY,
  input  logic [15:0] S_ARADDR,
  input  logic        S_ARVALID,
  output logic        S_ARREADY,
  output logic [31:0] S_RDATA,
  output logic [1:0]  S_RRESP,
  output logic        S_RVALID,
  input  logic        S_RREADY,
  output logic [15:0] WRADDR,
  output logic [3:0]  BYTEEN,
  output logic        WREN,
  output logic [31:0] WDATA,
  output logic [15:0] RDADDR,
  output logic        RDEN,
  input  logic [31:0] RDATA
);

  typedef enum logic [2:0] {IDLE, WEXE, WRESP, REXE, RWAIT, RRESP} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_aw_cap;
  logic        r_w_cap;
  logic [13:0] r_awaddr;
  logic [31:0] r_wdata_q;
  logic [3:0]  r_wstrb_q;
  logic        r_last_wr;
  logic [1:0]  r_cnt;

  logic [15:0] r_wraddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_byteen;
  logic        r_wren;
  logic [15:0] r_rdaddr;
  logic        r_rden;
  logic        r_bvalid;
  logic        r_rvalid;
  logic [31:0] r_rdata;

  logic        w_idle;
  logic        w_arready;
  logic        w_awready;
  logic        w_wready;
  logic        w_ar_hs;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_have;
  logic        w_w_have;
  logic        w_cnt_done;
  logic        w_enter_wexe;
  logic        w_unused;

  assign w_unused = ^{S_AWADDR[1:0], S_ARADDR[1:0]};

  // Reads are only offered with no write half-captured; on a tie with AW the
  // type not served last wins, and a granted read masks AW/W ready that cycle.
  assign w_idle    = (r_state == IDLE);
  assign w_arready = ~ARST & w_idle & ~r_aw_cap & ~r_w_cap & ~(S_AWVALID & ~r_last_wr);
  assign w_ar_hs   = w_arready & S_ARVALID;
  assign w_awready = ~ARST & w_idle & ~r_aw_cap & ~w_ar_hs;
  assign w_wready  = ~ARST & w_idle & ~r_w_cap & ~w_ar_hs;
  assign w_aw_hs   = w_awready & S_AWVALID;
  assign w_w_hs    = w_wready & S_WVALID;

  assign w_aw_have    = r_aw_cap | w_aw_hs;
  assign w_w_have     = r_w_cap | w_w_hs;
  assign w_cnt_done   = (r_cnt == 2'(RD_LATENCY));
  assign w_enter_wexe = w_idle & (w_next == WEXE);

  always_ff @(posedge ACLK) begin
    if (ARST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ar_hs)                   w_next = REXE;
        else if (w_aw_have & w_w_have) w_next = WEXE;
      end
      WEXE:    w_next = WRESP;
      WRESP:   if (S_BREADY) w_next = IDLE;
      REXE:    w_next = RWAIT;
      RWAIT:   if (w_cnt_done) w_next = RRESP;
      RRESP:   if (S_RREADY) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_awaddr  <= '0;
      r_wdata_q <= '0;
      r_wstrb_q <= '0;
      r_last_wr <= 1'b0;
      r_cnt     <= '0;
      r_wraddr  <= '0;
      r_wdata   <= '0;
      r_byteen  <= '0;
      r_wren    <= 1'b0;
      r_rdaddr  <= '0;
      r_rden    <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_wren   <= (w_next == WEXE);
      r_rden   <= (w_next == REXE);
      r_bvalid <= (w_next == WRESP);
      r_rvalid <= (w_next == RRESP);

      if (w_aw_hs) begin
        r_aw_cap <= 1'b1;
        r_awaddr <= S_AWADDR[15:2];
      end
      if (w_w_hs) begin
        r_w_cap   <= 1'b1;
        r_wdata_q <= S_WDATA;
        r_wstrb_q <= S_WSTRB;
      end
      // Bus-side write fields move only when the strobe fires, taking
      // same-cycle handshake data directly.
      if (w_enter_wexe) begin
        r_aw_cap <= 1'b0;
        r_w_cap  <= 1'b0;
        r_wraddr <= {(w_aw_hs ? S_AWADDR[15:2] : r_awaddr), 2'b00};
        r_wdata  <= w_w_hs ? S_WDATA : r_wdata_q;
        r_byteen <= w_w_hs ? S_WSTRB : r_wstrb_q;
      end

      if (w_ar_hs) r_rdaddr <= {S_ARADDR[15:2], 2'b00};

      if (r_state == REXE) begin
        r_cnt <= 2'd1;
      end else if (r_state == RWAIT) begin
        if (w_cnt_done) begin
          r_rdata <= RDATA;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 2'd1;
        end
      end

      if ((r_state == WRESP) && S_BREADY) r_last_wr <= 1'b1;
      if ((r_state == RRESP) && S_RREADY) r_last_wr <= 1'b0;
    end
  end

  assign S_AWREADY = w_awready;
  assign S_WREADY  = w_wready;
  assign S_ARREADY = w_arready;
  assign S_BVALID  = r_bvalid;
  assign S_BRESP   = 2'b00;
  assign S_RVALID  = r_rvalid;
  assign S_RRESP   = 2'b00;
  assign S_RDATA   = r_rdata;
  assign WRADDR    = r_wraddr;
  assign WDATA     = r_wdata;
  assign BYTEEN    = r_byteen;
  assign WREN      = r_wren;
  assign RDADDR    = r_rdaddr;
  assign RDEN      = r_rden;

endmodule

// File: tb/tb_disp_axil_regbus.sv
// Bench for disp_axil_regbus: fixed-latency register responder, word-array
// reference model, directed table, tie/reset sequences and random traffic.
module tb_disp_axil_regbus;
  localparam int LAT = 2;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [15:0] S_AWADDR;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [15:0] S_ARADDR;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA = '0;

  always #5 ACLK = ~ACLK;

  disp_axil_regbus #(.RD_LATENCY(LAT)) dut (
    .ACLK(ACLK), .ARST(ARST),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Register responder: RDATA valid exactly LAT cycles after RDEN, noise otherwise.
  logic [31:0] bmem [16];
  bit          mem_loaded = 1'b0;
  logic        p_v = 1'b0;
  logic [15:0] p_a = '0;
  always @(posedge ACLK) begin
    p_v   <= RDEN;
    p_a   <= RDADDR;
    RDATA <= p_v ? bmem[p_a[5:2]] : $urandom;
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) bmem[i] <= (i == 3) ? 32'hDEADBEEF : 32'h0;
      mem_loaded <= 1'b1;
    end else if (WREN) begin
      for (int b = 0; b < 4; b++)
        if (BYTEEN[b]) bmem[WRADDR[5:2]][8*b +: 8] <= WDATA[8*b +: 8];
    end
  end

  typedef struct packed {logic [15:0] a; logic [31:0] d; logic [3:0] s;} wrec_t;
  wrec_t       wq[$];
  int          wren_cnt = 0;
  int          rden_cnt = 0;
  int          vld_cnt  = 0;
  int          wren_cyc = -1;
  bit          overlap  = 1'b0;
  logic [15:0] last_rdaddr = '0;
  always @(negedge ACLK) begin
    if (WREN) begin
      wq.push_back({WRADDR, WDATA, BYTEEN});
      wren_cnt++;
      wren_cyc = cyc;
    end
    if (RDEN) begin
      rden_cnt++;
      last_rdaddr = RDADDR;
    end
    if (WREN && RDEN) overlap = 1'b1;
    if (S_BVALID || S_RVALID) vld_cnt++;
  end

  // Reference model: word array with byte-masked updates.
  logic [31:0] mmem [16];
  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  task automatic model_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    mmem[a[5:2]] = (mmem[a[5:2]] & ~bmask(s)) | (d & bmask(s));
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp, output int hs_c, output int b_c, output bit to);
    bit awp = 1, wp = 1, awf, wf, done = 0;
    int n = 0, seen = 0;
    to = 0; hs_c = -1; b_c = -1; resp = 2'b11;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
    while ((awp || wp) && n < 100) begin
      S_AWVALID = awp && (n >= aw_dly);
      S_WVALID  = wp && (n >= w_dly);
      @(negedge ACLK);
      awf = S_AWVALID && S_AWREADY;
      wf  = S_WVALID && S_WREADY;
      if ((awf || wf) && !(awp && !awf) && !(wp && !wf)) hs_c = cyc;
      @(posedge ACLK); #1;
      if (awf) awp = 0;
      if (wf)  wp = 0;
      n++;
    end
    S_AWVALID = 0; S_WVALID = 0;
    if (awp || wp) to = 1;
    else begin
      S_BREADY = (b_dly == 0);
      n = 0;
      while (!done && n < 100) begin
        @(negedge ACLK);
        if (S_BVALID) begin
          if (seen == 0) begin b_c = cyc; resp = S_BRESP; end
          seen++;
          if (S_BREADY) done = 1;
        end
        @(posedge ACLK); #1;
        n++;
        if (seen >= b_dly) S_BREADY = 1;
      end
      S_BREADY = 0;
      if (!done) to = 1;
    end
  endtask

  task automatic axi_read(input logic [15:0] a, input int r_dly, output logic [31:0] data,
                          output logic [1:0] resp, output int held, output bit stable, output bit to);
    bit f = 0, done = 0;
    int n = 0, seen = 0;
    data = '0; resp = 2'b11; stable = 1; to = 0;
    S_ARADDR = a; S_ARVALID = 1;
    while (!f && n < 100) begin
      @(negedge ACLK);
      f = S_ARREADY;
      @(posedge ACLK); #1;
      n++;
    end
    S_ARVALID = 0;
    if (!f) to = 1;
    else begin
      S_RREADY = (r_dly == 0);
      n = 0;
      while (!done && n < 100) begin
        @(negedge ACLK);
        if (S_RVALID) begin
          if (seen == 0) begin data = S_RDATA; resp = S_RRESP; end
          else if (S_RDATA !== data) stable = 0;
          seen++;
          if (S_RREADY) done = 1;
        end
        @(posedge ACLK); #1;
        n++;
        if (seen >= r_dly) S_RREADY = 1;
      end
      S_RREADY = 0;
      if (!done) to = 1;
    end
    held = seen;
  endtask

  task automatic do_wr(input string nm, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int aw_dly, input int w_dly, input int b_dly, input logic [15:0] exp_a);
    int w0 = wren_cnt, hs_c, b_c;
    logic [1:0] resp;
    bit to;
    wrec_t r;
    axi_write(a, d, s, aw_dly, w_dly, b_dly, resp, hs_c, b_c, to);
    check({nm, "_timeout"}, 64'(to), 64'(0));
    check({nm, "_wren_count"}, 64'(wren_cnt - w0), 64'(1));
    r = (wq.size() > 0) ? wq.pop_front() : '0;
    wq.delete();
    check({nm, "_bus_write"}, 64'(r), 64'({exp_a, d, s}));
    check({nm, "_bresp"}, 64'(resp), 64'(0));
    if (aw_dly == 0 && w_dly == 0) begin
      check({nm, "_wren_lat"}, 64'(wren_cyc - hs_c), 64'(1));
      check({nm, "_bvalid_lat"}, 64'(b_c - hs_c), 64'(2));
    end
    model_wr(a, d, s);
  endtask

  task automatic do_rd(input string nm, input logic [15:0] a, input int r_dly, input logic [31:0] exp_d);
    int r0 = rden_cnt, held;
    logic [31:0] d;
    logic [1:0] resp;
    bit stable, to;
    axi_read(a, r_dly, d, resp, held, stable, to);
    check({nm, "_timeout"}, 64'(to), 64'(0));
    check({nm, "_rdata"}, 64'(d), 64'(exp_d));
    check({nm, "_rresp"}, 64'(resp), 64'(0));
    check({nm, "_rden_count"}, 64'(rden_cnt - r0), 64'(1));
    check({nm, "_rdaddr"}, 64'(last_rdaddr), 64'({a[15:2], 2'b00}));
    check({nm, "_rvalid_held"}, 64'(held), 64'(r_dly + 1));
    check({nm, "_rdata_stable"}, 64'(stable), 64'(1));
  endtask

  task automatic tie(input logic [15:0] a, input logic [31:0] d, output bit wr_first,
                     output logic [2:0] rdy0, output logic [31:0] rdata, output bit to);
    bit awp = 1, wp = 1, arp = 1, awf, wf, arf;
    int n = 0, bn = 0, rn = 0, w_c = -1, r_c = -1;
    rdata = '0; rdy0 = '0;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = 4'hF; S_ARADDR = a;
    S_BREADY = 1; S_RREADY = 1;
    while ((awp || wp || arp || bn == 0 || rn == 0) && n < 100) begin
      S_AWVALID = awp; S_WVALID = wp; S_ARVALID = arp;
      @(negedge ACLK);
      if (n == 0) rdy0 = {S_AWREADY, S_WREADY, S_ARREADY};
      awf = S_AWVALID && S_AWREADY;
      wf  = S_WVALID && S_WREADY;
      arf = S_ARVALID && S_ARREADY;
      if (S_BVALID) bn++;
      if (S_RVALID) begin rn++; rdata = S_RDATA; end
      if (WREN && w_c < 0) w_c = cyc;
      if (RDEN && r_c < 0) r_c = cyc;
      @(posedge ACLK); #1;
      if (awf) awp = 0;
      if (wf)  wp = 0;
      if (arf) arp = 0;
      n++;
    end
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 0; S_RREADY = 0;
    to = awp || wp || arp || bn == 0 || rn == 0;
    wr_first = (w_c >= 0) && (r_c >= 0) && (w_c < r_c);
    wq.delete();
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          resp_dly;
    logic [15:0] exp_addr;
    logic [31:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vt [10];
    bit wr_first, to, seen;
    logic [2:0] rdy0;
    logic [31:0] rd, exp_rd;
    int v0, wr0, rd0;

    vt[0] = '{1, 16'h0004, 32'h00000003, 4'h1, 0, 0, 0, 16'h0004, 32'h0};
    vt[1] = '{1, 16'h0008, 32'hCAFEF00D, 4'hF, 3, 0, 1, 16'h0008, 32'h0};
    vt[2] = '{1, 16'h0007, 32'hAABBCCDD, 4'hF, 0, 2, 0, 16'h0004, 32'h0};
    vt[3] = '{0, 16'h0006, 32'h0,        4'h0, 0, 0, 0, 16'h0,    32'hAABBCCDD};
    vt[4] = '{1, 16'h0004, 32'h11223344, 4'h0, 0, 0, 0, 16'h0004, 32'h0};
    vt[5] = '{0, 16'h0005, 32'h0,        4'h0, 0, 0, 1, 16'h0,    32'hAABBCCDD};
    vt[6] = '{1, 16'h0012, 32'h12345678, 4'h6, 1, 1, 2, 16'h0010, 32'h0};
    vt[7] = '{0, 16'h0013, 32'h0,        4'h0, 0, 0, 0, 16'h0,    32'h00345600};
    vt[8] = '{0, 16'h000A, 32'h0,        4'h0, 0, 0, 0, 16'h0,    32'hCAFEF00D};
    vt[9] = '{0, 16'h000C, 32'h0,        4'h0, 0, 0, 5, 16'h0,    32'hDEADBEEF};

    for (int i = 0; i < 16; i++) mmem[i] = (i == 3) ? 32'hDEADBEEF : 32'h0;
    S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0; S_ARADDR = '0;
    S_AWVALID = 1; S_WVALID = 1; S_ARVALID = 1; S_BREADY = 0; S_RREADY = 0;
    ARST = 1;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_ctl", 64'({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, S_BRESP, S_RRESP,
                          WREN, RDEN, BYTEEN}), 64'(0));
    check("rst_data", 64'({S_RDATA, WDATA}), 64'(0));
    check("rst_addr", 64'({WRADDR, RDADDR}), 64'(0));
    @(posedge ACLK); #1;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
    ARST = 0;

    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr)
        do_wr($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].strb,
              vt[i].aw_dly, vt[i].w_dly, vt[i].resp_dly, vt[i].exp_addr);
      else
        do_rd($sformatf("vec%0d", i), vt[i].addr, vt[i].resp_dly, vt[i].exp_rdata);
    end

    // After the table the last grant is a read, so a write should win the tie.
    tie(16'h0020, 32'h5A5A0001, wr_first, rdy0, rd, to);
    model_wr(16'h0020, 32'h5A5A0001, 4'hF);
    check("tie1_timeout", 64'(to), 64'(0));
    check("tie1_write_first", 64'(wr_first), 64'(1));
    check("tie1_readys", 64'(rdy0), 64'(3'b110));
    check("tie1_rdata", 64'(rd), 64'(mmem[8]));

    do_wr("pre_tie2", 16'h0024, 32'h0BADF00D, 4'hF, 0, 0, 0, 16'h0024);
    exp_rd = mmem[8];
    tie(16'h0020, 32'h5A5A0002, wr_first, rdy0, rd, to);
    model_wr(16'h0020, 32'h5A5A0002, 4'hF);
    check("tie2_timeout", 64'(to), 64'(0));
    check("tie2_read_first", 64'(wr_first), 64'(0));
    check("tie2_readys", 64'(rdy0), 64'(3'b001));
    check("tie2_rdata", 64'(rd), 64'(exp_rd));
    do_rd("tie2_after", 16'h0020, 0, 32'h5A5A0002);

    // Reset while the read is waiting for responder data.
    S_ARADDR = 16'h000C; S_ARVALID = 1;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ACLK);
      seen = S_ARREADY;
      @(posedge ACLK); #1;
    end
    S_ARVALID = 0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge ACLK);
      seen = RDEN;
    end
    check("abort_rden_seen", 64'(seen), 64'(1));
    @(posedge ACLK); #1;
    ARST = 1;
    @(posedge ACLK); #1;
    @(negedge ACLK);
    check("abort_rst_ctl", 64'({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID, S_BRESP, S_RRESP,
                                WREN, RDEN, BYTEEN}), 64'(0));
    check("abort_rst_data", 64'({S_RDATA, WDATA}), 64'(0));
    check("abort_rst_addr", 64'({WRADDR, RDADDR}), 64'(0));
    @(posedge ACLK); #1;
    ARST = 0;
    v0 = vld_cnt; wr0 = wren_cnt; rd0 = rden_cnt;
    @(negedge ACLK);
    check("abort_release_readys", 64'({S_AWREADY, S_WREADY, S_ARREADY}), 64'(3'b111));
    repeat (8) @(posedge ACLK);
    #1;
    check("abort_no_activity", 64'((vld_cnt - v0) + (wren_cnt - wr0) + (rden_cnt - rd0)), 64'(0));
    do_rd("abort_then_read", 16'h000C, 0, 32'hDEADBEEF);

    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        do_wr($sformatf("rnd%0d_wr", i), a, $urandom, 4'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2), {a[15:2], 2'b00});
      else
        do_rd($sformatf("rnd%0d_rd", i), a, $urandom_range(0, 2), mmem[a[5:2]]);
    end

    check("wren_rden_exclusive", 64'(overlap), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
